// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks active-low rows, debounces the first key seen
// and reports it as one-hot row/column plus a one-cycle new_key strobe.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 100000,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_r,
  output logic [3:0] key_c,
  output logic       new_key,
  output logic       key_held
);

  localparam int unsigned CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       col_s_q, col_s_d;
  logic [3:0]       col_lat_q, col_lat_d;
  logic [3:0]       row_n_q, row_n_d;
  logic [3:0]       key_r_q, key_r_d;
  logic [3:0]       key_c_q, key_c_d;
  logic             new_key_q, new_key_d;
  logic             key_held_q, key_held_d;

  logic [3:0]       col_act;
  logic [3:0]       col_first;
  logic             lat_active;

  // Active columns after synchronisation; lowest-index active column isolated.
  always_comb begin
    col_act    = ~col_s_q;
    col_first  = col_act & (~col_act + 4'd1);
    lat_active = |(col_act & col_lat_q);
  end

  always_comb begin
    state_d    = state_q;
    row_idx_d  = row_idx_q;
    cnt_d      = cnt_q;
    sync1_d    = col_n;
    col_s_d    = sync1_q;
    col_lat_d  = col_lat_q;
    key_r_d    = key_r_q;
    key_c_d    = key_c_q;
    new_key_d  = 1'b0;

    case (state_q)
      ST_SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (|col_act) begin
            col_lat_d = col_first;
            state_d   = ST_DEBOUNCE;
          end else begin
            row_idx_d = row_idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DEBOUNCE: begin
        if (!lat_active) begin
          state_d   = ST_SCAN;
          row_idx_d = row_idx_q + 2'd1;
          cnt_d     = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d   = ST_HELD;
          cnt_d     = '0;
          key_r_d   = 4'b0001 << row_idx_q;
          key_c_d   = col_lat_q;
          new_key_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Only the latched column on the frozen row is watched; other keys are ignored.
      ST_HELD: begin
        if (!lat_active) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end
      end

      ST_RELEASE: begin
        if (lat_active) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d   = ST_SCAN;
          row_idx_d = row_idx_q + 2'd1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_SCAN;
        cnt_d   = '0;
      end
    endcase

    row_n_d    = ~(4'b0001 << row_idx_d);
    key_held_d = (state_d == ST_HELD) || (state_d == ST_RELEASE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_SCAN;
      row_idx_q  <= 2'd0;
      cnt_q      <= '0;
      sync1_q    <= 4'b1111;
      col_s_q    <= 4'b1111;
      col_lat_q  <= 4'b0000;
      row_n_q    <= 4'b1110;
      key_r_q    <= 4'b0000;
      key_c_q    <= 4'b0000;
      new_key_q  <= 1'b0;
      key_held_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_idx_q  <= row_idx_d;
      cnt_q      <= cnt_d;
      sync1_q    <= sync1_d;
      col_s_q    <= col_s_d;
      col_lat_q  <= col_lat_d;
      row_n_q    <= row_n_d;
      key_r_q    <= key_r_d;
      key_c_q    <= key_c_d;
      new_key_q  <= new_key_d;
      key_held_q <= key_held_d;
    end
  end

  assign row_n    = row_n_q;
  assign key_r    = key_r_q;
  assign key_c    = key_c_q;
  assign new_key  = new_key_q;
  assign key_held = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a combinational keypad matrix model.
module tb_keypad_scanner;

  logic       clk;
  logic       reset;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_r;
  logic [3:0] key_c;
  logic       new_key;
  logic       key_held;

  logic [3:0][3:0] keys;
  int checks = 0;
  int errors = 0;
  int nk_cnt = 0;
  int nk_base;
  bit ok;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .col_n    (col_n),
    .row_n    (row_n),
    .key_r    (key_r),
    .key_c    (key_c),
    .new_key  (new_key),
    .key_held (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pressed key on the driven row pulls its column low.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row_n[r]) col_n = col_n & ~keys[r];
  end

  always @(posedge clk) if (new_key) nk_cnt <= nk_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_new_key(input int max, output bit found);
    found = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick(1);
      if (new_key) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_row(input logic [3:0] target, input int max, output bit found);
    found = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick(1);
      if (row_n == target) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    keys  = '0;
    reset = 1'b0;
    tick(3);
    check("rst_row_n", 32'(row_n), 32'h0E);
    check("rst_key_r", 32'(key_r), 32'h0);
    check("rst_key_c", 32'(key_c), 32'h0);
    check("rst_new_key", 32'(new_key), 32'h0);
    check("rst_key_held", 32'(key_held), 32'h0);

    // 1: idle scanning
    reset = 1'b1;
    tick(3);  check("scan_r0", 32'(row_n), 32'h0E);
    tick(1);  check("scan_r1", 32'(row_n), 32'h0D);
    tick(4);  check("scan_r2", 32'(row_n), 32'h0B);
    tick(4);  check("scan_r3", 32'(row_n), 32'h07);
    tick(4);  check("scan_wrap", 32'(row_n), 32'h0E);
    check("idle_no_new_key", 32'(nk_cnt), 32'h0);

    // 2: hold row1/col2
    keys[1][2] = 1'b1;
    tick(15);
    check("press_pre_nk", 32'(new_key), 32'h0);
    check("press_pre_held", 32'(key_held), 32'h0);
    tick(1);
    check("press_nk", 32'(new_key), 32'h1);
    check("press_key_r", 32'(key_r), 32'h2);
    check("press_key_c", 32'(key_c), 32'h4);
    check("press_held", 32'(key_held), 32'h1);
    tick(1);
    check("press_nk_pulse", 32'(new_key), 32'h0);
    tick(20);
    check("hold_row_frozen", 32'(row_n), 32'h0D);
    check("hold_held", 32'(key_held), 32'h1);
    check("hold_single_nk", 32'(nk_cnt), 32'h1);

    // 4: release glitch, then full release
    keys[1][2] = 1'b0;
    tick(3);
    check("glitch_held_mid", 32'(key_held), 32'h1);
    keys[1][2] = 1'b1;
    tick(10);
    check("glitch_held", 32'(key_held), 32'h1);
    check("glitch_row", 32'(row_n), 32'h0D);
    check("glitch_no_nk", 32'(nk_cnt), 32'h1);
    keys[1][2] = 1'b0;
    tick(10);
    check("rel_held_pre", 32'(key_held), 32'h1);
    tick(1);
    check("rel_held", 32'(key_held), 32'h0);
    check("rel_row_adv", 32'(row_n), 32'h0B);
    check("rel_key_r_kept", 32'(key_r), 32'h2);
    check("rel_key_c_kept", 32'(key_c), 32'h4);

    // 3: short press on row0/col0
    wait_row(4'hE, 40, ok);
    check("short_row0_to", 32'(ok), 32'h1);
    keys[0][0] = 1'b1;
    tick(5);
    keys[0][0] = 1'b0;
    tick(2);
    check("short_row_frozen", 32'(row_n), 32'h0E);
    tick(1);
    check("short_resume_r1", 32'(row_n), 32'h0D);
    tick(10);
    check("short_no_nk", 32'(nk_cnt), 32'h1);
    check("short_key_c_kept", 32'(key_c), 32'h4);

    // 5: two keys on row3, then a foreign key while held
    nk_base = nk_cnt;
    keys[3][0] = 1'b1;
    keys[3][3] = 1'b1;
    wait_new_key(80, ok);
    check("multi_nk_to", 32'(ok), 32'h1);
    check("multi_key_r", 32'(key_r), 32'h8);
    check("multi_key_c", 32'(key_c), 32'h1);
    keys[0][1] = 1'b1;
    tick(40);
    check("multi_ignored_nk", 32'(nk_cnt - nk_base), 32'h1);
    check("multi_ignored_c", 32'(key_c), 32'h1);
    check("multi_row_frozen", 32'(row_n), 32'h7);
    check("multi_held", 32'(key_held), 32'h1);

    // 6b: reset while HELD
    reset = 1'b0;
    #1;
    check("rh_row_n", 32'(row_n), 32'h0E);
    check("rh_key_r", 32'(key_r), 32'h0);
    check("rh_key_c", 32'(key_c), 32'h0);
    check("rh_held", 32'(key_held), 32'h0);
    check("rh_nk", 32'(new_key), 32'h0);
    keys = '0;
    tick(2);
    nk_base = nk_cnt;
    reset = 1'b1;
    tick(30);
    check("rh_no_nk_after", 32'(nk_cnt - nk_base), 32'h0);
    check("rh_held_after", 32'(key_held), 32'h0);

    // 6a: reset while DEBOUNCE on row2
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    keys[2][1] = 1'b1;
    tick(14);
    check("rd_row_pre", 32'(row_n), 32'h0B);
    check("rd_nk_pre", 32'(nk_cnt - nk_base), 32'h0);
    reset = 1'b0;
    #1;
    check("rd_row_n", 32'(row_n), 32'h0E);
    check("rd_nk", 32'(new_key), 32'h0);
    check("rd_held", 32'(key_held), 32'h0);
    check("rd_key_r", 32'(key_r), 32'h0);
    tick(2);
    keys = '0;
    reset = 1'b1;
    tick(30);
    check("rd_no_nk_after", 32'(nk_cnt - nk_base), 32'h0);
    check("rd_held_after", 32'(key_held), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
